// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg
// Shared state and grant encodings for the fetch/data memory port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    function automatic arb_state_e busy_state(input arb_gnt_e gnt);
        return (gnt == GNT_D) ? ARB_BUSY_D : ARB_BUSY_I;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Serialises core fetch and load/store requests onto one req/ack memory bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e              state_q, state_d;
    logic [SW-1:0]           streak_q, streak_d;
    logic                    drop_i_q, drop_i_d;
    logic                    i_done_q, i_done_d;
    logic                    d_done_q, d_done_d;
    logic                    i_valid_q, i_valid_d;
    logic                    d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic                    complete_i, complete_d, arb_en;
    logic                    i_elig, d_elig;
    arb_gnt_e                gnt;

    always_comb begin
        complete_i = (state_q == ARB_BUSY_I) && mem_ack;
        complete_d = (state_q == ARB_BUSY_D) && mem_ack;
        arb_en     = (state_q == ARB_IDLE) || complete_i || complete_d;

        // A requester still holds req while its own response is being
        // completed or strobed, so it must not be granted a second time.
        i_elig = i_req && !complete_i && !i_done_q;
        d_elig = d_req && !complete_d && !d_done_q;
        gnt    = (d_elig && !(i_elig && (streak_q == STREAK_MAX))) ? GNT_D : GNT_I;

        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = complete_i;
        d_done_d    = complete_d;
        i_valid_d   = complete_i && !drop_i_q && !i_flush;
        d_valid_d   = complete_d;
        drop_i_d    = complete_i ? 1'b0
                                 : (drop_i_q || ((state_q == ARB_BUSY_I) && i_flush));

        if (complete_i) begin
            i_rdata_d = mem_rdata;
        end
        if (complete_d && !mem_we_q) begin
            d_rdata_d = mem_rdata;
        end

        if (arb_en) begin
            if (i_elig || d_elig) begin
                state_d   = busy_state(gnt);
                mem_req_d = 1'b1;
                if (gnt == GNT_D) begin
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    streak_d   = '0;
                end
            end else begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            drop_i_q    <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_i_q    <= drop_i_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_valid   = i_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire
